// File: rtl/universal_reg_if.sv
// Control/data bundle for the universal register.
// The master drives the controls; the slave returns q, flags and serial out.
interface universal_reg_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             clear;
  logic             preset;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             ser_in;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic             ser_out;
  logic             tc;
  logic             ovf;

  modport master (
    output en, clear, preset, mode, d, ser_in,
    input  q, qbar, ser_out, tc, ovf
  );

  modport slave (
    input  en, clear, preset, mode, d, ser_in,
    output q, qbar, ser_out, tc, ovf
  );
endinterface

// File: rtl/universal_reg.sv
// Universal register: load, shift, rotate and up/down count,
// with a sticky wrap flag and a registered serial output.
module universal_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic            clk,
  input logic            clear_n,
  universal_reg_if.slave bus
);

  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_LOAD = 3'b001,
    M_SHL  = 3'b010,
    M_SHR  = 3'b011,
    M_ROL  = 3'b100,
    M_ROR  = 3'b101,
    M_UP   = 3'b110,
    M_DN   = 3'b111
  } mode_e;

  logic [WIDTH-1:0] r_q;
  logic             r_ser_out;
  logic             r_ovf;

  logic [WIDTH-1:0] w_q_nxt;
  logic             w_so_nxt;
  logic             w_ovf_nxt;
  logic             w_all_ones;
  logic             w_zero;
  mode_e            w_mode;

  assign w_mode     = mode_e'(bus.mode);
  assign w_all_ones = &r_q;
  assign w_zero     = ~|r_q;

  always_comb begin
    w_q_nxt   = r_q;
    w_so_nxt  = r_ser_out;
    w_ovf_nxt = r_ovf;
    if (!bus.en) begin
      w_q_nxt = r_q;
    end else if (bus.clear) begin
      w_q_nxt   = '0;
      w_ovf_nxt = 1'b0;
    end else if (bus.preset) begin
      w_q_nxt   = '1;
      w_ovf_nxt = 1'b0;
    end else begin
      unique case (w_mode)
        M_HOLD: w_q_nxt = r_q;
        M_LOAD: begin
          w_q_nxt   = bus.d;
          w_ovf_nxt = 1'b0;
        end
        M_SHL: begin
          w_q_nxt  = {r_q[WIDTH-2:0], bus.ser_in};
          w_so_nxt = r_q[WIDTH-1];
        end
        M_SHR: begin
          w_q_nxt  = {bus.ser_in, r_q[WIDTH-1:1]};
          w_so_nxt = r_q[0];
        end
        M_ROL: begin
          w_q_nxt  = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
          w_so_nxt = r_q[WIDTH-1];
        end
        M_ROR: begin
          w_q_nxt  = {r_q[0], r_q[WIDTH-1:1]};
          w_so_nxt = r_q[0];
        end
        M_UP: begin
          w_q_nxt = r_q + 1'b1;
          if (w_all_ones) w_ovf_nxt = 1'b1;
        end
        M_DN: begin
          w_q_nxt = r_q - 1'b1;
          if (w_zero) w_ovf_nxt = 1'b1;
        end
        default: w_q_nxt = r_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      r_q       <= RESET_VAL;
      r_ser_out <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_q       <= w_q_nxt;
      r_ser_out <= w_so_nxt;
      r_ovf     <= w_ovf_nxt;
    end
  end

  assign bus.q       = r_q;
  assign bus.qbar    = ~r_q;
  assign bus.ser_out = r_ser_out;
  assign bus.ovf     = r_ovf;
  // Terminal count looks at the mode on the wires now, not gated by en.
  assign bus.tc = ((w_mode == M_UP) && w_all_ones) ||
                  ((w_mode == M_DN) && w_zero);

endmodule

// File: doc/universal_reg.md
UNIVERSAL_REG -- requirements
Module: universal_reg

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; legal range 2..32.
REQ-002 Parameter RESET_VAL, default 0, WIDTH-bit value loaded into q by reset.
REQ-003 clk  input  1  clock; every state change on rising edge.
REQ-004 clear_n  input  1  reset; synchronous, active-low.
REQ-005 en  input  1  clock enable; when low, all state holds.
REQ-006 clear  input  1  synchronous clear-to-zero, active-high.
REQ-007 preset  input  1  synchronous preset-to-ones, active-high.
REQ-008 mode  input  3  operation select, see REQ-013.
REQ-009 d  input  WIDTH  parallel load data.
REQ-010 ser_in  input  1  serial input for shift modes.
REQ-011 q  output  WIDTH  registered value; qbar  output  WIDTH  bitwise ~q, combinational.
REQ-012 ser_out  output  1  last bit shifted/rotated out, registered; tc  output  1  terminal count, combinational; ovf  output  1  sticky count-wrap flag, registered.

Function
REQ-013 mode encoding: 000 hold, 001 load, 010 shift left, 011 shift right, 100 rotate left, 101 rotate right, 110 count up, 111 count down.
REQ-014 Edge priority, highest first: clear_n low; en low; clear; preset; mode.
REQ-015 en low (clear_n high): q, ser_out, ovf hold regardless of clear, preset, mode.
REQ-016 clear high (en high): q <= 0, ovf <= 0, ser_out holds; overrides preset when both high.
REQ-017 preset high, clear low (en high): q <= all ones, ovf <= 0, ser_out holds.
REQ-018 Load: q <= d, ovf <= 0, ser_out holds.
REQ-019 Shift left: q <= {q[WIDTH-2:0], ser_in}, ser_out <= q[WIDTH-1].
REQ-020 Shift right: q <= {ser_in, q[WIDTH-1:1]}, ser_out <= q[0].
REQ-021 Rotate left: q <= {q[WIDTH-2:0], q[WIDTH-1]}, ser_out <= q[WIDTH-1]; ser_in ignored.
REQ-022 Rotate right: q <= {q[0], q[WIDTH-1:1]}, ser_out <= q[0]; ser_in ignored.
REQ-023 Count up: q <= q + 1 modulo 2^WIDTH; all-ones wraps to 0 and sets ovf.
REQ-024 Count down: q <= q - 1 modulo 2^WIDTH; zero wraps to all-ones and sets ovf.
REQ-025 ovf is sticky: once set, cleared only by reset, clear, preset or load; hold/shift/rotate/non-wrapping counts leave it unchanged.
REQ-026 tc = 1 iff (mode==110 and q all ones) or (mode==111 and q==0); otherwise 0; not gated by en.
REQ-027 Hold mode and count modes leave ser_out unchanged.
REQ-028 Load, shift, rotate and count take effect in q one cycle after the sampling edge (latency 1); no multi-cycle operations.
REQ-029 mode changes between any two cycles are legal; each edge acts only on the mode sampled at that edge.

Reset
REQ-030 clear_n low at a rising edge: q <= RESET_VAL, ser_out <= 0, ovf <= 0, regardless of en, clear, preset, mode.
REQ-031 Asserting clear_n mid-operation (any mode) aborts it at that edge; no partial update.
REQ-032 Before the first reset edge, output values are undefined; no asynchronous path from clear_n, clear or preset to q.

Verification (WIDTH=8, RESET_VAL=8'hA5 unless stated)
REQ-033 clear_n low 1 edge with en=0, mode=110 -> q=8'hA5, qbar=8'h5A, ser_out=0, ovf=0.
REQ-034 Load 8'h81, then shift left ser_in=0 twice -> q=8'h02 then 8'h04, ser_out=1 then 0; then rotate right -> q=8'h02, ser_out=0.
REQ-035 Load 8'hFE, count up 3 edges -> q=FF (tc=1 before 2nd edge), 00 (ovf=1), 01 (ovf stays 1); hold 2 edges -> unchanged.
REQ-036 q=8'h00, count down -> q=8'hFF, ovf=1; tc=1 while q=0 with mode=111, tc=0 with mode=110.
REQ-037 clear=1 and preset=1 same edge, en=1 -> q=8'h00, ovf=0; with en=0 same inputs -> q unchanged.
REQ-038 clear_n low coinciding with count-up wrap from 8'hFF -> q=8'hA5, ovf=0.
